// File: rtl/tree_result_serializer_if.sv
// Handshake and data bundle between the vector producer, the serializer and
// the element consumer. The master side is the serializer itself.
interface tree_result_serializer_if #(
    parameter int N = 64
);
    localparam int IW = $clog2(N);

    logic              valid_in;
    logic [15:0]       sum_in;
    logic [N*16-1:0]   data_in;
    logic              clr_ovf;
    logic              m_ready;
    logic              m_valid;
    logic [15:0]       m_data;
    logic [15:0]       m_sum;
    logic [IW-1:0]     m_idx;
    logic              m_last;
    logic [1:0]        free_cnt;
    logic              overflow;

    modport master (
        input  valid_in, sum_in, data_in, clr_ovf, m_ready,
        output m_valid, m_data, m_sum, m_idx, m_last, free_cnt, overflow
    );

    modport slave (
        output valid_in, sum_in, data_in, clr_ovf, m_ready,
        input  m_valid, m_data, m_sum, m_idx, m_last, free_cnt, overflow
    );
endinterface

// File: rtl/tree_result_serializer.sv
// Two-bank vector buffer that streams captured Q4.12 vectors out one element
// per handshake, together with the reduction sum captured alongside them.
module tree_result_serializer #(
    parameter int N = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    tree_result_serializer_if.master      bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    logic [N-1:0][15:0] bank_data [2];
    logic [15:0]        bank_sum  [2];

    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic [1:0]    free_q;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [IW-1:0] idx;
    logic          ovf;

    logic m_valid_w;
    logic hs;
    logic freeing;
    logic cap;
    logic drop;

    assign m_valid_w = (count != 2'd0);
    assign hs        = m_valid_w & bus.m_ready;
    assign freeing   = hs & (idx == IDX_MAX);
    // A bank released by the last-element handshake is reusable on the same edge.
    assign cap       = bus.valid_in & ((count != 2'd2) | freeing);
    assign drop      = bus.valid_in & (count == 2'd2) & ~freeing;

    // Occupancy bookkeeping for simultaneous capture and release.
    always_comb begin
        count_nxt = count;
        if (cap && !freeing)
            count_nxt = count + 2'd1;
        else if (!cap && freeing)
            count_nxt = count - 2'd1;
    end

    // Control state: pointers, occupancy, element index and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            free_q <= 2'd2;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= '0;
            ovf    <= 1'b0;
        end else begin
            count  <= count_nxt;
            free_q <= 2'd2 - count_nxt;
            if (cap)
                wr_ptr <= ~wr_ptr;
            if (hs) begin
                if (idx == IDX_MAX) begin
                    idx    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (drop)
                ovf <= 1'b1;
            else if (bus.clr_ovf)
                ovf <= 1'b0;
        end
    end

    // Bank storage; contents are don't-care until captured, so no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            bank_data[wr_ptr] <= bus.data_in;
            bank_sum[wr_ptr]  <= bus.sum_in;
        end
    end

    assign bus.m_valid  = m_valid_w;
    assign bus.m_data   = bank_data[rd_ptr][idx];
    assign bus.m_sum    = bank_sum[rd_ptr];
    assign bus.m_idx    = idx;
    assign bus.m_last   = m_valid_w & (idx == IDX_MAX);
    assign bus.free_cnt = free_q;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_tree_result_serializer.sv
// Randomized and directed stimulus against a queue-based reference model.
module tb_tree_result_serializer;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    tree_result_serializer_if #(.N(N)) bus ();

    tree_result_serializer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*16-1:0] d;
        logic [15:0]     s;
    } vec_t;

    vec_t q[$];
    int   e_pos;
    logic m_ovf;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_pos = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N*16-1:0] v;
        logic            ev;
        ev = (q.size() > 0);
        chk("m_valid", {31'd0, bus.m_valid}, {31'd0, ev});
        chk("m_last", {31'd0, bus.m_last}, {31'd0, ev && (e_pos == N - 1)});
        chk("free_cnt", {30'd0, bus.free_cnt}, 32'(2 - q.size()));
        chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
        chk("m_idx", 32'(bus.m_idx), 32'(e_pos));
        if (ev) begin
            v = q[0].d;
            chk("m_data", {16'd0, bus.m_data}, {16'd0, v[e_pos*16 +: 16]});
            chk("m_sum", {16'd0, bus.m_sum}, {16'd0, q[0].s});
        end
    endtask

    // Drive one cycle's inputs, check the current outputs, then advance the
    // model across the coming rising edge.
    task automatic cycle(input logic v, input logic [15:0] s, input logic [N*16-1:0] d,
                         input logic rdy, input logic clr);
        int   sz;
        logic freeing;
        vec_t nv;
        @(negedge clk);
        bus.valid_in = v;
        bus.sum_in   = s;
        bus.data_in  = d;
        bus.m_ready  = rdy;
        bus.clr_ovf  = clr;
        check_outputs();
        sz      = q.size();
        freeing = 1'b0;
        if (sz > 0 && rdy) begin
            if (e_pos == N - 1) begin
                freeing = 1'b1;
                e_pos   = 0;
                void'(q.pop_front());
            end else begin
                e_pos++;
            end
        end
        if (v) begin
            if (sz < 2 || freeing) begin
                nv.d = d;
                nv.s = s;
                q.push_back(nv);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (clr && !(v && sz == 2 && !freeing))
            m_ovf = 1'b0;
        @(posedge clk);
    endtask

    function automatic logic [N*16-1:0] rand_vec();
        logic [N*16-1:0] r;
        for (int i = 0; i < N; i++)
            r[i*16 +: 16] = 16'($urandom);
        return r;
    endfunction

    logic [N*16-1:0] vec_a;
    logic [N*16-1:0] vec_b;

    initial begin
        bus.valid_in = 1'b0;
        bus.sum_in   = '0;
        bus.data_in  = '0;
        bus.m_ready  = 1'b0;
        bus.clr_ovf  = 1'b0;
        model_reset();
        #12;
        chk("reset_free_cnt", {30'd0, bus.free_cnt}, 32'd2);
        chk("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single vector, full-rate drain.
        vec_a = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        cycle(1'b1, 16'hA000, vec_a, 1'b1, 1'b0);
        for (int i = 0; i < N + 2; i++) cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);

        // Stall at idx 1 for three cycles.
        cycle(1'b1, 16'h1234, rand_vec(), 1'b1, 1'b0);
        cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, '0, 1'b0, 1'b0);
        for (int i = 0; i < N + 1; i++) cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);

        // Three pulses with no drain: third is dropped, then cleared.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 1), rand_vec(), 1'b0, 1'b0);
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
        chk("full_free_cnt", {30'd0, bus.free_cnt}, 32'd0);
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b1);

        // Full, capture on the same edge as the last-element handshake.
        for (int i = 0; i < N - 1; i++) cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);
        cycle(1'b1, 16'h7777, rand_vec(), 1'b1, 1'b0);
        for (int i = 0; i < 3 * N + 2; i++) cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);

        // Two vectors back to back.
        vec_b = rand_vec();
        cycle(1'b1, 16'h1111, rand_vec(), 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, vec_b, 1'b0, 1'b0);
        for (int i = 0; i < 2 * N + 1; i++) cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges mid-drain.
        cycle(1'b1, 16'h5555, rand_vec(), 1'b1, 1'b0);
        cycle(1'b1, 16'h6666, rand_vec(), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("arst_free_cnt", {30'd0, bus.free_cnt}, 32'd2);
        chk("arst_m_idx", 32'(bus.m_idx), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        cycle(1'b1, 16'h9999, rand_vec(), 1'b1, 1'b0);
        for (int i = 0; i < N + 1; i++) cycle(1'b0, 16'h0, '0, 1'b1, 1'b0);

        // Random traffic with varying load and backpressure.
        for (int ph = 0; ph < 8; ph++) begin
            int pv;
            int pr;
            pv = $urandom_range(5, 60);
            pr = $urandom_range(20, 100);
            for (int i = 0; i < 300; i++)
                cycle(($urandom_range(0, 99) < pv), 16'($urandom), rand_vec(),
                      ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tree_result_serializer.md
TREE_RESULT_SERIALIZER -- requirements
Module: tree_result_serializer

Interface
REQ-001 SHALL have parameter N, default 64, number of Q4.12 elements per vector (power of two, >= 2).
REQ-002 SHALL have localparam IW = $clog2(N), the element index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_in  input  1  sum_in/data_in valid this cycle (no backpressure upstream).
REQ-006 SHALL have port sum_in  input  16  Q4.12 reduction sum of the vector.
REQ-007 SHALL have port data_in  input  N*16  Q4.12 vector, element i at bits [i*16 +: 16].
REQ-008 SHALL have port clr_ovf  input  1  clears sticky overflow.
REQ-009 SHALL have port m_ready  input  1  downstream accepts current element.
REQ-010 SHALL have port m_valid  output  1  m_* fields hold a valid element.
REQ-011 SHALL have port m_data  output  16  current element, Q4.12, unmodified.
REQ-012 SHALL have port m_sum  output  16  sum captured with the current vector.
REQ-013 SHALL have port m_idx  output  IW  index of current element.
REQ-014 SHALL have port m_last  output  1  high when m_idx == N-1 and m_valid.
REQ-015 SHALL have port free_cnt  output  2  empty buffer banks (0..2).
REQ-016 SHALL have port overflow  output  1  sticky: a valid_in vector was dropped.

Function
REQ-017 SHALL hold two banks (vector + sum each) as a FIFO of depth 2; write pointer, read pointer, count registered.
REQ-018 SHALL capture data_in and sum_in into the write bank on a rising edge where valid_in=1 and a bank is free, including a bank freed that same edge.
REQ-019 SHALL treat a bank as freed on the edge where m_valid=1, m_ready=1, m_last=1 (simultaneous free and capture legal at count 2).
REQ-020 SHALL drop the vector and set overflow on an edge where valid_in=1, count=2 and no bank frees that edge; stored banks unchanged.
REQ-021 SHALL clear overflow on an edge with clr_ovf=1 unless a drop occurs the same edge (set wins).
REQ-022 SHALL assert m_valid whenever count >= 1; first element visible the cycle after capture (latency 1 edge).
REQ-023 SHALL drive m_data = read bank element m_idx, m_sum = read bank sum, both purely from registers.
REQ-024 SHALL advance m_idx by 1 on each edge with m_valid & m_ready; at N-1 wrap to 0 and advance read pointer.
REQ-025 SHALL hold m_data, m_sum, m_idx stable while m_valid=1 and m_ready=0.
REQ-026 SHALL present elements in order 0..N-1, vectors in capture order; no element skipped or repeated.
REQ-027 SHALL stream back-to-back vectors with no idle cycle when the next bank is full at m_last handshake.
REQ-028 SHALL have free_cnt = 2 - count, registered.
REQ-029 SHALL ignore m_ready when m_valid=0.

Reset
REQ-030 SHALL on rst=1 asynchronously force count=0, pointers=0, m_idx=0, overflow=0, m_valid=0, m_last=0, free_cnt=2.
REQ-031 SHALL on reset mid-drain discard both banks; bank contents need not be cleared, m_data/m_sum don't-care while m_valid=0.
REQ-032 SHALL accept valid_in on the first rising edge after rst deasserts.

Verification
REQ-033 SHALL pass: N=4, vector {0x1000,0x2000,0x3000,0x4000} sum 0xA000, m_ready=1 -> m_data 0x1000..0x4000 on 4 consecutive cycles, m_sum=0xA000, m_last only on 4th, free_cnt back to 2.
REQ-034 SHALL pass: m_ready low 3 cycles at m_idx=1 -> m_data/m_idx held, then resumes at idx 1 with no skip.
REQ-035 SHALL pass: three valid_in pulses on consecutive cycles, m_ready=0 -> first two stored, overflow=1, free_cnt=0; clr_ovf -> overflow=0.
REQ-036 SHALL pass: count=2, valid_in on same edge as m_last handshake -> new vector accepted, overflow stays 0, free_cnt stays 0.
REQ-037 SHALL pass: two vectors captured, m_ready=1 -> 2N elements with no gap, m_sum switches at element N.
REQ-038 SHALL pass: rst pulse asynchronously between edges during drain -> m_valid=0 immediately, free_cnt=2, next vector streams from idx 0.
